// File: rtl/reg_disp_pkg.sv
// Shared types and constants for the register-debug seven-segment scanner.
// Segment codes are active-low {dp, g, f, e, d, c, b, a}.
package reg_disp_pkg;

  typedef enum logic [1:0] {
    SEL  = 2'd0,
    CAP  = 2'd1,
    SCAN = 2'd2
  } state_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  localparam logic [7:0] SEG_TABLE [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage

// File: rtl/reg_disp_scan_if.sv
// Register-debug read port plus the seven-segment display outputs.
// master = scanner side, slave = CPU register file / board side.
interface reg_disp_scan_if;

  logic [4:0]  reg_sel;
  logic [31:0] reg_data;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic [4:0]  cur_reg;

  modport master (
    output reg_sel, an, seg, cur_reg,
    input  reg_data
  );

  modport slave (
    input  reg_sel, an, seg, cur_reg,
    output reg_data
  );

endinterface

// File: rtl/reg_disp_scan_hex7seg.sv
// Combinational hex nibble to active-low seven-segment decoder (dp always off).
module hex7seg
  import reg_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/reg_disp_scan.sv
// Snapshots one register-file entry and time-multiplexes it as 8 hex digits
// onto an active-low 8-digit display; manual or auto-stepping register select.
module reg_disp_scan
  import reg_disp_pkg::*;
#(
  parameter int DIGIT_CYCLES   = 100000,
  parameter int REG_HOLD_SCANS = 250
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              mode,
  input  logic [4:0]        sel_in,
  input  logic              freeze,
  reg_disp_scan_if.master   bus
);

  localparam int DIV_W  = $clog2(DIGIT_CYCLES);
  localparam int SCAN_W = (REG_HOLD_SCANS > 1) ? $clog2(REG_HOLD_SCANS) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIGIT_CYCLES - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(REG_HOLD_SCANS - 1);

  state_e             state;
  state_e             state_next;
  logic [DIV_W-1:0]   div_cnt;
  logic [2:0]         digit;
  logic [SCAN_W-1:0]  scan_cnt;
  logic [4:0]         auto_idx;
  logic [31:0]        snapshot;

  logic               blank;
  logic               scan_last;
  logic [3:0]         nibble;
  logic [7:0]         digit_seg;

  // First cycle of each digit slot is dark so the previous digit cannot ghost.
  assign blank     = (div_cnt == '0);
  assign scan_last = (digit == 3'd7) && (div_cnt == DIV_LAST);
  assign nibble    = snapshot[4*digit +: 4];

  hex7seg u_hex7seg (
    .nibble (nibble),
    .seg    (digit_seg)
  );

  // NOTE: registers are updated with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= SEL;
    else       state <= state_next;
  end

  // NOTE: the default at the top of the block guarantees every path assigns
  // state_next, so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      SEL:     state_next = CAP;
      CAP:     state_next = SCAN;
      SCAN:    if (scan_last) state_next = SEL;
      default: state_next = SEL;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.reg_sel <= '0;
      bus.cur_reg <= '0;
      bus.an      <= AN_OFF;
      bus.seg     <= SEG_BLANK;
      snapshot    <= '0;
      digit       <= '0;
      div_cnt     <= '0;
      scan_cnt    <= '0;
      auto_idx    <= '0;
    end else begin
      bus.an  <= AN_OFF;
      bus.seg <= SEG_BLANK;
      unique case (state)
        SEL: bus.reg_sel <= mode ? auto_idx : sel_in;
        CAP: begin
          // reg_data is combinational from the CPU for the reg_sel set in SEL.
          if (!freeze) begin
            snapshot    <= bus.reg_data;
            bus.cur_reg <= bus.reg_sel;
          end
        end
        SCAN: begin
          if (!blank) begin
            bus.an  <= ~(8'h01 << digit);
            bus.seg <= digit_seg;
          end
          // digit wraps 7 -> 0 on its own, leaving counters ready for the next scan.
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            digit   <= digit + 3'd1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
          if (scan_last && mode && !freeze) begin
            if (scan_cnt == SCAN_LAST) begin
              scan_cnt <= '0;
              auto_idx <= auto_idx + 5'd1;
            end else begin
              scan_cnt <= scan_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_disp_scan.sv
// Scoreboard bench for reg_disp_scan: stimulus queues expected digits,
// a negedge monitor pops and compares each newly lit digit.
module tb_reg_disp_scan;

  logic       clk;
  logic       rstn;
  logic       mode;
  logic [4:0] sel_in;
  logic       freeze;

  reg_disp_scan_if bus ();

  logic [31:0] rf [32];
  assign bus.reg_data = rf[bus.reg_sel];

  reg_disp_scan #(.DIGIT_CYCLES(4), .REG_HOLD_SCANS(2)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .mode   (mode),
    .sel_in (sel_in),
    .freeze (freeze),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] an;
    logic [7:0] seg;
  } exp_t;

  exp_t exp_q [$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   gap_cnt  = 0;
  int   dig_cnt  = 0;
  int   gap_period = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] tb_seg(input logic [3:0] h);
    case (h)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  task automatic push_scan(input logic [31:0] value);
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      e.an  = ~(8'h01 << k);
      e.seg = tb_seg(value[4*k +: 4]);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: a gap is two consecutive dark samples (SEL+CAP); a digit event is
  // the first lit sample after a dark one.
  initial begin
    int   ff_run = 0;
    int   cyc = 0;
    int   last_gap = 0;
    logic [7:0] prev_an = 8'hFF;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rstn) begin
        ff_run  = 0;
        dig_cnt = 0;
        prev_an = 8'hFF;
      end else begin
        if (bus.an == 8'hFF) begin
          ff_run++;
          if (ff_run == 2) begin
            gap_period = cyc - last_gap;
            last_gap   = cyc;
            gap_cnt++;
            dig_cnt = 0;
          end
        end else begin
          ff_run = 0;
          if (prev_an == 8'hFF) begin
            dig_cnt++;
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              check("digit_an", {24'h0, bus.an}, {24'h0, e.an});
              check("digit_seg", {24'h0, bus.seg}, {24'h0, e.seg});
            end
          end
        end
        prev_an = bus.an;
      end
    end
  end

  task automatic wait_gaps(input int n);
    int target;
    target = gap_cnt + n;
    for (int c = 0; c < n * 40 + 80 && gap_cnt < target; c++) @(negedge clk);
    check("gap_wait", {31'h0, gap_cnt >= target}, 32'd1);
  endtask

  task automatic wait_digit(input int k);
    for (int c = 0; c < 80 && dig_cnt < k; c++) @(negedge clk);
    check("digit_wait", {31'h0, dig_cnt >= k}, 32'd1);
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 400 && exp_q.size() > 0; c++) @(negedge clk);
    check("drain", exp_q.size(), 32'd0);
  endtask

  initial begin
    int prev, run, trans, ff_cnt, viol;
    logic first;

    for (int i = 0; i < 32; i++) rf[i] = 32'hA500_0000 | i;
    rf[3] = 32'hCAFE_0003;
    rf[5] = 32'hDEAD_BEEF;
    rf[7] = 32'h1234_5678;
    rstn = 1'b1; mode = 1'b0; sel_in = 5'd7; freeze = 1'b0;

    // Reset: asynchronous, then edge-by-edge start-up sequence
    #13 rstn = 1'b0;
    #1;
    check("rst_an", {24'h0, bus.an}, 32'hFF);
    check("rst_seg", {24'h0, bus.seg}, 32'hFF);
    check("rst_reg_sel", {27'h0, bus.reg_sel}, 32'd0);
    check("rst_cur_reg", {27'h0, bus.cur_reg}, 32'd0);
    push_scan(rf[7]);
    #19;
    @(negedge clk) rstn = 1'b1;
    @(posedge clk) #1;
    check("e1_reg_sel", {27'h0, bus.reg_sel}, 32'd7);
    check("e1_an", {24'h0, bus.an}, 32'hFF);
    check("e1_cur_reg", {27'h0, bus.cur_reg}, 32'd0);
    @(posedge clk) #1;
    check("e2_cur_reg", {27'h0, bus.cur_reg}, 32'd7);
    check("e2_an", {24'h0, bus.an}, 32'hFF);
    @(posedge clk) #1;
    check("e3_an", {24'h0, bus.an}, 32'hFF);
    @(posedge clk) #1;
    check("e4_an", {24'h0, bus.an}, 32'hFE);
    wait_drain();
    check("man_cur_reg7", {27'h0, bus.cur_reg}, 32'd7);

    // Manual decode of a second register
    sel_in = 5'd5;
    wait_gaps(2);
    push_scan(32'hDEAD_BEEF);
    wait_drain();
    check("man_cur_reg5", {27'h0, bus.cur_reg}, 32'd5);

    // Auto step through r0..r31 and wrap; first auto value is a partial hold
    mode = 1'b1;
    prev = bus.reg_sel; run = 0; trans = 0; first = 1'b1;
    for (int c = 0; c < 3000 && trans < 33; c++) begin
      @(negedge clk);
      if (bus.reg_sel != prev[4:0]) begin
        check("auto_next", {27'h0, bus.reg_sel}, first ? 32'd0 : 32'((prev + 1) % 32));
        if (trans >= 2) check("auto_hold", run, 32'd68);
        first = 1'b0; prev = bus.reg_sel; run = 1; trans++;
        @(negedge clk); run++;
        check("cur_follow", {27'h0, bus.cur_reg}, {27'h0, bus.reg_sel});
      end else begin
        run++;
      end
    end
    check("auto_trans", trans, 32'd33);

    // Freeze: display and cur_reg hold while r7 changes, auto index stalls
    mode = 1'b0; sel_in = 5'd7;
    wait_gaps(2);
    freeze = 1'b1; mode = 1'b1;
    rf[7] = 32'hFFFF_FFFF;
    wait_gaps(1);
    push_scan(32'h1234_5678);
    wait_drain();
    check("frz_cur_reg", {27'h0, bus.cur_reg}, 32'd7);
    check("frz_reg_sel", {27'h0, bus.reg_sel}, 32'd0);
    wait_gaps(5);
    check("frz_no_adv", {27'h0, bus.reg_sel}, 32'd0);
    check("frz_cur_hold", {27'h0, bus.cur_reg}, 32'd7);
    mode = 1'b0; freeze = 1'b0;
    wait_gaps(2);
    push_scan(32'hFFFF_FFFF);
    wait_drain();
    check("unfrz_cur_reg", {27'h0, bus.cur_reg}, 32'd7);
    mode = 1'b1;
    wait_gaps(1);
    check("resume_idx", {27'h0, bus.reg_sel}, 32'd0);
    mode = 1'b0;

    // Blanking and scan period over one full steady scan
    sel_in = 5'd7;
    wait_gaps(1);
    ff_cnt = 0; viol = 0;
    for (int c = 0; c < 34; c++) begin
      @(negedge clk);
      if (bus.an == 8'hFF) ff_cnt++;
      if ($countones(~bus.an) > 1) viol++;
    end
    check("blank_count", ff_cnt, 32'd10);
    check("onehot_viol", viol, 32'd0);
    check("scan_period", gap_period, 32'd34);

    // Mid-scan select change, then reset mid-scan
    rf[7] = 32'h1234_5678;
    wait_gaps(2);
    push_scan(32'h1234_5678);
    wait_digit(5);
    sel_in = 5'd3;
    wait_drain();
    wait_gaps(1);
    check("mid_reg_sel", {27'h0, bus.reg_sel}, 32'd3);
    push_scan(rf[3]);
    wait_drain();
    check("mid_cur_reg", {27'h0, bus.cur_reg}, 32'd3);
    wait_gaps(1);
    wait_digit(6);
    #2 rstn = 1'b0;
    #1;
    check("rst2_an", {24'h0, bus.an}, 32'hFF);
    check("rst2_seg", {24'h0, bus.seg}, 32'hFF);
    check("rst2_reg_sel", {27'h0, bus.reg_sel}, 32'd0);
    check("rst2_cur_reg", {27'h0, bus.cur_reg}, 32'd0);
    push_scan(rf[3]);
    #17;
    @(negedge clk) rstn = 1'b1;
    wait_drain();
    check("post_rst_cur_reg", {27'h0, bus.cur_reg}, 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
